spi_read_scheduler: RTL and testbench

- Sequences the shared input-only SPI master across NCH slave devices: ADC/encoder feedback sensors for the PID loop.
- Collects periodic and on-demand read requests, then picks one with a round-robin arbiter.
- Pulses the master's start, steers per-device chip selects and tracks the master's cs (busy-low).
- Presents each completed word with its channel tag and a one-cycle valid strobe.

---
 rtl/spi_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/spi_read_scheduler.sv | 126 ++++++++++++
 tb/tb_spi_read_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI read scheduler.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    LATCH     = 3'd4
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among pending channels, starting just after the last grant.
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int NCH = 2,
  localparam int CW = chw(NCH)
) (
  input  logic [CW-1:0]  last,
  input  logic [NCH-1:0] pending,
  output logic [CW-1:0]  grant,
  output logic           any
);

  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;
  int               pick;
  int               off;

  always_comb begin
    dbl  = {pending, pending};
    // rot[j] holds the request of channel (last + 1 + j) mod NCH
    rot  = NCH'(dbl >> (int'(last) + 1));
    pick = 0;
    any  = 1'b0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (rot[j]) begin
        pick = j;
        any  = 1'b1;
      end
    end
    off = int'(last) + 1 + pick;
    if (off >= NCH) off = off - NCH;
    grant = CW'(off);
  end

endmodule

// File: rtl/spi_read_scheduler.sv
// Schedules periodic and on-demand reads of NCH SPI sensors through one shared master.
//   state     | meaning
//   IDLE      | pick next pending channel
//   START     | one-cycle start strobe to the master
//   WAIT_BUSY | wait for master cs low, bounded by TMO
//   WAIT_DONE | transfer in progress
//   LATCH     | capture the returned word
module spi_read_scheduler
  import spi_pkg::*;
#(
  parameter int BITS   = 4,
  parameter int NCH    = 2,
  parameter int PERIOD = 255,
  parameter int TMO    = 3,
  localparam int CW = chw(NCH),
  localparam int TW = chw(PERIOD),
  localparam int WW = chw(TMO + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [NCH-1:0]  req,
  output logic            spi_start,
  input  logic            spi_cs,
  input  logic [BITS-1:0] spi_data,
  output logic [NCH-1:0]  cs_n,
  output logic [BITS-1:0] sample,
  output logic [CW-1:0]   sample_ch,
  output logic            sample_valid,
  output logic            overrun,
  output logic            timeout
);

  state_t         state, state_nxt;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] set_mask, clr_mask;
  logic [TW-1:0]  timer;
  logic           tick;
  logic [CW-1:0]  cur, last, grant;
  logic           any;
  logic [WW-1:0]  wcnt;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .last    (last),
    .pending (pending),
    .grant   (grant),
    .any     (any)
  );

  assign tick    = enable && (timer == TW'(PERIOD - 1));
  assign overrun = tick && (pending != '0);

  always_ff @(posedge clk) begin
    if (reset || !enable) timer <= '0;
    else if (tick)        timer <= '0;
    else                  timer <= timer + 1'b1;
  end

  // A set in the same cycle as the grant clear wins, so that request is served again.
  always_comb begin
    clr_mask = '0;
    if (state == IDLE && any) clr_mask = NCH'(1) << grant;
    set_mask = req;
    if (tick)    set_mask = '1;
    if (timeout) set_mask = set_mask | (NCH'(1) << cur);
  end

  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (any) state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!spi_cs)                 state_nxt = WAIT_DONE;
        else if (wcnt == WW'(TMO))   state_nxt = IDLE;
      end
      WAIT_DONE: if (spi_cs) state_nxt = LATCH;
      LATCH:     state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    spi_start = (state == START);
    timeout   = (state == WAIT_BUSY) && spi_cs && (wcnt == WW'(TMO));
  end

  // sample_valid is registered so it lines up with the registered sample/sample_ch.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur          <= '0;
      last         <= CW'(NCH - 1);
      wcnt         <= '0;
      sample       <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= (state == LATCH);
      if (state == IDLE && any) begin
        cur  <= grant;
        last <= grant;
      end
      if (state == START) wcnt <= '0;
      else if (state == WAIT_BUSY && spi_cs && wcnt != WW'(TMO)) wcnt <= wcnt + 1'b1;
      if (state == LATCH) begin
        sample    <= spi_data;
        sample_ch <= cur;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) cs_n[i] = spi_cs | (cur != CW'(i));
  end

endmodule

// File: tb/tb_spi_read_scheduler.sv
// Directed bench: two schedulers (PERIOD 40 and 20) each driving a behavioural SPI master.
module tb_spi_read_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       a_enable, a_start, a_cs, a_valid, a_ovr, a_tmo, a_ch, a_hang;
  logic [1:0] a_req, a_csn;
  logic [3:0] a_data, a_sample;
  logic       b_enable, b_start, b_cs, b_valid, b_ovr, b_tmo, b_ch;
  logic [1:0] b_req, b_csn;
  logic [3:0] b_data, b_sample;

  spi_read_scheduler #(.BITS(4), .NCH(2), .PERIOD(40), .TMO(3)) u_a (
    .clk(clk), .reset(reset), .enable(a_enable), .req(a_req),
    .spi_start(a_start), .spi_cs(a_cs), .spi_data(a_data), .cs_n(a_csn),
    .sample(a_sample), .sample_ch(a_ch), .sample_valid(a_valid),
    .overrun(a_ovr), .timeout(a_tmo)
  );

  spi_read_scheduler #(.BITS(4), .NCH(2), .PERIOD(20), .TMO(3)) u_b (
    .clk(clk), .reset(reset), .enable(b_enable), .req(b_req),
    .spi_start(b_start), .spi_cs(b_cs), .spi_data(b_data), .cs_n(b_csn),
    .sample(b_sample), .sample_ch(b_ch), .sample_valid(b_valid),
    .overrun(b_ovr), .timeout(b_tmo)
  );

  // Master model: cs low the cycle after start for 24 cycles, then word A (ch0) or 5 (ch1).
  int a_cnt, b_cnt;
  always @(posedge clk) begin
    if (reset) begin
      a_cs <= 1'b1; a_cnt <= 0; a_data <= 4'h0;
    end else if (a_cs && a_start && !a_hang) begin
      a_cs <= 1'b0; a_cnt <= 24;
    end else if (!a_cs) begin
      a_cnt <= a_cnt - 1;
      if (a_cnt == 1) begin
        a_cs   <= 1'b1;
        a_data <= a_csn[0] ? 4'h5 : 4'hA;
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      b_cs <= 1'b1; b_cnt <= 0; b_data <= 4'h0;
    end else if (b_cs && b_start) begin
      b_cs <= 1'b0; b_cnt <= 24;
    end else if (!b_cs) begin
      b_cnt <= b_cnt - 1;
      if (b_cnt == 1) begin
        b_cs   <= 1'b1;
        b_data <= b_csn[0] ? 4'h5 : 4'hA;
      end
    end
  end

  int a_starts = 0, a_ovrs = 0, a_valids = 0, a_viol = 0;
  always @(negedge clk) begin
    if (a_start) a_starts++;
    if (a_ovr) a_ovrs++;
    if (a_valid) a_valids++;
    if (a_start && !a_cs) a_viol++;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_a_start(input string tag, input int lim);
    bit found = 1'b0;
    for (int i = 0; i < lim && !found; i++) begin
      cyc(1);
      found = a_start;
    end
    check({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  task automatic wait_a_valid(input string tag, input int lim, input logic [3:0] d, input logic ch);
    bit found = 1'b0;
    for (int i = 0; i < lim && !found; i++) begin
      cyc(1);
      found = a_valid;
    end
    check({tag, "_seen"}, 32'(found), 32'd1);
    check({tag, "_data"}, 32'(a_sample), 32'(d));
    check({tag, "_ch"}, 32'(a_ch), 32'(ch));
  endtask

  initial begin
    int s0, o0, v0, n_ovr, first, nval, prev, alt_err;
    reset = 1'b1; a_hang = 1'b0;
    a_enable = 1'b0; a_req = 2'b11;
    b_enable = 1'b0; b_req = 2'b00;

    // Reset held with requests asserted: everything quiet
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("reset_quiet", {a_start, a_valid, a_ovr, a_tmo, a_csn}, 32'h03);
    end
    s0 = a_starts;
    reset = 1'b0;
    cyc(1);
    a_req = 2'b00;
    wait_a_start("rr_ch0", 10);
    cyc(1);
    check("sel_ch0", a_csn, 2'b10);
    wait_a_valid("rr_ch0", 60, 4'hA, 1'b0);
    wait_a_start("rr_ch1", 10);
    cyc(1);
    check("sel_ch1", a_csn, 2'b01);
    wait_a_valid("rr_ch1", 60, 4'h5, 1'b1);
    cyc(40);
    check("rr_starts", a_starts - s0, 2);

    // Periodic round, PERIOD=40
    o0 = a_ovrs;
    a_enable = 1'b1;
    wait_a_valid("per_ch0", 120, 4'hA, 1'b0);
    wait_a_valid("per_ch1", 60, 4'h5, 1'b1);
    a_enable = 1'b0;
    check("per_no_overrun", a_ovrs - o0, 0);
    wait_a_valid("drain_ch0", 60, 4'hA, 1'b0);
    wait_a_valid("drain_ch1", 60, 4'h5, 1'b1);

    // PERIOD=20: overrun from the second tick on, channels alternate
    n_ovr = 0; first = -1; nval = 0; prev = -1; alt_err = 0;
    b_enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (b_ovr) begin
        n_ovr++;
        if (first < 0) first = i;
      end
      if (b_valid) begin
        nval++;
        if (int'(b_ch) == prev) alt_err++;
        prev = int'(b_ch);
      end
      cyc(1);
    end
    b_enable = 1'b0;
    check("ovr_count", n_ovr, 4);
    check("ovr_first", first, 39);
    check("ovr_valids", nval, 2);
    check("ovr_alternate", alt_err, 0);

    // Repeated req[1] during a ch1 transfer coalesces into one extra read
    s0 = a_starts;
    a_req = 2'b10;
    cyc(1);
    a_req = 2'b00;
    wait_a_start("rq", 10);
    cyc(3);
    repeat (3) begin
      a_req = 2'b10;
      cyc(1);
      a_req = 2'b00;
      cyc(2);
    end
    wait_a_valid("rq_first", 40, 4'h5, 1'b1);
    wait_a_valid("rq_extra", 60, 4'h5, 1'b1);
    cyc(60);
    check("rq_once", a_starts - s0, 2);

    // Master never goes busy: timeout 4 cycles after start, then retry
    a_hang = 1'b1;
    a_req = 2'b01;
    cyc(1);
    a_req = 2'b00;
    wait_a_start("to", 10);
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      check("to_early", {a_tmo, a_csn}, 32'h3);
    end
    cyc(1);
    check("to_pulse", a_tmo, 1);
    a_hang = 1'b0;
    cyc(2);
    check("to_retry", a_start, 1);
    wait_a_valid("to_data", 60, 4'hA, 1'b0);

    // Reset in the middle of a transfer
    a_req = 2'b10;
    cyc(1);
    a_req = 2'b00;
    wait_a_start("rst", 10);
    cyc(5);
    check("rst_busy_sel", a_csn, 2'b01);
    v0 = a_valids;
    reset = 1'b1;
    cyc(1);
    check("rst_clear", {a_sample, a_valid, a_start, a_csn}, 32'h03);
    cyc(1);
    reset = 1'b0;
    cyc(40);
    check("rst_no_valid", a_valids - v0, 0);
    check("rst_sample_zero", a_sample, 0);
    a_req = 2'b10;
    cyc(1);
    a_req = 2'b00;
    wait_a_valid("rst_after", 60, 4'h5, 1'b1);

    check("no_start_busy", a_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
